// File: rtl/door_lock_pkg.sv
// door_lock_pkg
//   Shared types and constants for the push-button door lock.
//   - state_t         : controller states (S_LOCKED only reachable when
//                       DOOR_LOCK_LOCKOUT_EN is defined)
//   - DIGITS, DIG_W   : number of buttons and width of a digit index
//   - DIGIT_INVALID   : code for a zero-hot or multi-hot button value
//   - onehot_to_digit : button vector -> digit index or DIGIT_INVALID
package door_lock_pkg;

  localparam int DIGITS = 10;
  localparam int DIG_W  = 4;
  localparam logic [DIG_W-1:0] DIGIT_INVALID = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIG1,
    S_DIG2,
    S_DIG3,
    S_WAIT_DONE,
    S_PASS,
    S_FAIL,
    S_LOCKED
  } state_t;

  function automatic logic [DIG_W-1:0] onehot_to_digit(input logic [DIGITS-1:0] v);
    logic [DIG_W-1:0] d;
    int unsigned      hits;
    d    = DIGIT_INVALID;
    hits = 0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[i]) begin
        hits++;
        d = DIG_W'(i);
      end
    end
    if (hits != 1) d = DIGIT_INVALID;
    return d;
  endfunction

endpackage

// File: rtl/door_lock_button_encoder.sv
// button_encoder
//   Registers the raw button vector once and flags a press on the first
//   cycle any button is high after all buttons were released.
//   Ports:
//     clk    in   system clock
//     rst    in   asynchronous active-low reset
//     button in   [DIGITS-1:0] one bit per digit, active-high
//     press  out  one-cycle pulse per release-to-press transition
//     digit  out  [DIG_W-1:0] digit index, DIGIT_INVALID unless one-hot;
//                 valid while press is high
module button_encoder
  import door_lock_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DIGITS-1:0] button,
  output logic              press,
  output logic [DIG_W-1:0]  digit
);

  logic [DIGITS-1:0] button_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) button_q <= '0;
    else      button_q <= button;
  end

  // Held buttons keep button_q nonzero, so a long press yields one pulse.
  assign press = (|button) && !(|button_q);
  assign digit = onehot_to_digit(button);

endmodule

// File: rtl/door_lock_top.sv
// door_lock_top
//   Three-digit door lock controller. A session opened by start captures
//   three presses; digits 1 and 3 are compared with ANS1/ANS2 when done is
//   seen, and the pass or fail LED is lit for LED_ON_PERIOD cycles.
//   Optional feature macro: DOOR_LOCK_LOCKOUT_EN -- third consecutive
//   failure enters S_LOCKED (led=2'b11 for 4*LED_ON_PERIOD cycles).
//   Ports:
//     clk    in   system clock
//     rst    in   asynchronous active-low reset
//     start  in   level, opens a session in IDLE
//     done   in   level, requests evaluation
//     button in   [9:0] push buttons, one per digit
//     led    out  [1:0] led[0]=pass, led[1]=fail (registered)
module door_lock_top
  import door_lock_pkg::*;
#(
  parameter int ANS1          = 8,
  parameter int ANS2          = 0,
  parameter int LED_ON_PERIOD = 300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              done,
  input  logic [DIGITS-1:0] button,
  output logic [1:0]        led
);

  // The counter also times the lockout window when that feature is built in.
`ifdef DOOR_LOCK_LOCKOUT_EN
  localparam int CNT_SPAN = 4 * LED_ON_PERIOD;
`else
  localparam int CNT_SPAN = LED_ON_PERIOD;
`endif
  localparam int CNT_W = $clog2(CNT_SPAN + 1);
  localparam logic [CNT_W-1:0] LED_LOAD = CNT_W'(LED_ON_PERIOD - 1);

  logic             press;
  logic [DIG_W-1:0] digit;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIG_W-1:0] dig1_q, dig1_d, dig3_q, dig3_d;
  logic             err_q, err_d;
  logic [1:0]       led_d;
  logic             to_pass, to_fail;

`ifdef DOOR_LOCK_LOCKOUT_EN
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(4 * LED_ON_PERIOD - 1);
  logic [1:0] fail_q, fail_d;
`endif

  button_encoder u_enc (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .press  (press),
    .digit  (digit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dig1_q  <= '0;
      dig3_q  <= '0;
      err_q   <= 1'b0;
      led     <= 2'b00;
`ifdef DOOR_LOCK_LOCKOUT_EN
      fail_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig1_q  <= dig1_d;
      dig3_q  <= dig3_d;
      err_q   <= err_d;
      led     <= led_d;
`ifdef DOOR_LOCK_LOCKOUT_EN
      fail_q  <= fail_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dig1_d  = dig1_q;
    dig3_d  = dig3_q;
    err_d   = err_q;
    to_pass = 1'b0;
    to_fail = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DIG1;
          dig1_d  = '0;
          dig3_d  = '0;
          err_d   = 1'b0;
        end
      end
      // done takes priority over a simultaneous press: too few digits.
      S_DIG1: begin
        if (done) to_fail = 1'b1;
        else if (press) begin
          dig1_d  = digit;
          state_d = S_DIG2;
        end
      end
      S_DIG2: begin
        if (done)       to_fail = 1'b1;
        else if (press) state_d = S_DIG3;
      end
      S_DIG3: begin
        if (done) to_fail = 1'b1;
        else if (press) begin
          dig3_d  = digit;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (done) begin
          if (dig1_q == DIG_W'(ANS1) && dig3_q == DIG_W'(ANS2) && !err_q)
            to_pass = 1'b1;
          else
            to_fail = 1'b1;
        end else if (press) begin
          err_d = 1'b1;
        end
      end
      S_PASS, S_FAIL, S_LOCKED: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (to_pass) begin
      state_d = S_PASS;
      cnt_d   = LED_LOAD;
    end
    if (to_fail) begin
      state_d = S_FAIL;
      cnt_d   = LED_LOAD;
    end

`ifdef DOOR_LOCK_LOCKOUT_EN
    fail_d = fail_q;
    if (to_pass) fail_d = '0;
    if (to_fail) begin
      if (fail_q == 2'd2) begin
        state_d = S_LOCKED;
        cnt_d   = LOCK_LOAD;
        fail_d  = '0;
      end else begin
        fail_d = fail_q + 2'd1;
      end
    end
`endif
  end

  always_comb begin
    led_d = 2'b00;
    unique case (state_q)
      S_PASS:   led_d = 2'b01;
      S_FAIL:   led_d = 2'b10;
      S_LOCKED: led_d = 2'b11;
      default:  led_d = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_door_lock_top.sv
module tb_door_lock_top;

  localparam int A1 = 8;
  localparam int A2 = 0;
  localparam int P  = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       done = 1'b0;
  logic [9:0] button = '0;
  logic [1:0] led;

  int vectors = 0;
  int miscompares = 0;
  int fails = 0;  // consecutive failed sessions seen by the model

  typedef struct {
    logic [9:0] val;
    int         hold;
    int         rel;
  } press_t;
  press_t pq[$];

  door_lock_top #(.ANS1(A1), .ANS2(A2), .LED_ON_PERIOD(P)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .done   (done),
    .button (button),
    .led    (led)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_press(input logic [9:0] v, input int hold, input int rel);
    press_t p;
    p.val  = v;
    p.hold = hold;
    p.rel  = rel;
    pq.push_back(p);
  endtask

  task automatic add_digit(input int d);
    logic [9:0] one;
    one = 10'd1;
    add_press(one << d, 5, 5);
  endtask

  // Session verdict straight from the rules: exactly three presses, the
  // first equal to button ANS1 alone, the third equal to button ANS2 alone.
  function automatic bit model_pass();
    logic [9:0] one;
    one = 10'd1;
    if (pq.size() != 3) return 1'b0;
    return (pq[0].val == (one << A1)) && (pq[2].val == (one << A2));
  endfunction

  task automatic run_entry();
    start = 1'b1;
    repeat (5) tick();
    start = 1'b0;
    foreach (pq[i]) begin
      button = pq[i].val;
      repeat (pq[i].hold) tick();
      button = '0;
      repeat (pq[i].rel) tick();
    end
  endtask

  task automatic finish_session(input string name, input bit noise);
    logic [1:0] exp_val, on_val;
    logic [9:0] one;
    int exp_len, on_start, on_len;
    one = 10'd1;
    if (model_pass()) begin
      exp_val = 2'b01;
      exp_len = P;
      fails   = 0;
    end else begin
      fails++;
      exp_val = 2'b10;
      exp_len = P;
`ifdef DOOR_LOCK_LOCKOUT_EN
      if (fails == 3) begin
        exp_val = 2'b11;
        exp_len = 4 * P;
        fails   = 0;
      end
`endif
    end
    done     = 1'b1;
    on_start = -1;
    on_len   = 0;
    on_val   = 2'b00;
    for (int c = 1; c <= exp_len + 20; c++) begin
      tick();
      if (on_start < 0 && led != 2'b00) begin
        on_start = c;
        on_val   = led;
      end
      if (on_start >= 0) begin
        if (led == on_val) on_len++;
        else break;
      end
      if (c >= 5) begin
        done   = 1'b0;
        start  = 1'b0;
        button = '0;
        if (noise && c < exp_len - 10) begin
          start = 1'($urandom_range(1, 0));
          done  = ($urandom_range(3, 0) == 0);
          if ($urandom_range(2, 0) == 0) button = one << $urandom_range(9, 0);
        end
      end
    end
    done = 1'b0; start = 1'b0; button = '0;

    vectors++;
    if (on_start !== 2) begin
      miscompares++;
      $display("FAIL %s led_latency: got cycle %0d, expected cycle 2", name, on_start);
    end
    vectors++;
    if (on_val !== exp_val) begin
      miscompares++;
      $display("FAIL %s led_value: got %b, expected %b", name, on_val, exp_val);
    end
    vectors++;
    if (on_len !== exp_len) begin
      miscompares++;
      $display("FAIL %s led_length: got %0d, expected %0d", name, on_len, exp_len);
    end
    repeat (15) tick();
    vectors++;
    if (led !== 2'b00) begin
      miscompares++;
      $display("FAIL %s idle_after: got %b, expected 00", name, led);
    end
    pq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; done = 1'b1;
    #12;
    vectors++;
    if (led !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_led: got %b, expected 00", led);
    end
    repeat (3) tick();
    vectors++;
    if (led !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_hold: got %b, expected 00", led);
    end
    start = 1'b0; done = 1'b0;
    rst = 1'b1;
    fails = 0;
    repeat (3) tick();
  endtask

  task automatic test_directed();
    add_digit(8); add_digit(4); add_digit(0); run_entry(); finish_session("s840", 0);
    add_digit(8); add_digit(7); add_digit(0); run_entry(); finish_session("s870", 0);
    add_digit(1); add_digit(4); add_digit(3); run_entry(); finish_session("s143", 0);
    add_digit(8); add_digit(5); add_digit(8); run_entry(); finish_session("s858", 0);
    add_digit(7); add_digit(4); add_digit(2); run_entry(); finish_session("s742", 0);
    add_digit(8); add_digit(4);               run_entry(); finish_session("s84_short", 0);
    add_digit(8); add_digit(4); add_digit(0); add_digit(3);
    run_entry(); finish_session("s8403_extra", 0);
    add_press(10'b0100000000, 50, 5); add_digit(4); add_digit(0);
    run_entry(); finish_session("held8", 0);
    add_press(10'b0100000001, 5, 5); add_digit(4); add_digit(0);
    run_entry(); finish_session("multihot", 0);
  endtask

  task automatic test_ignore_in_result();
    add_digit(8); add_digit(4); add_digit(0); run_entry(); finish_session("noise_pass", 1);
    add_digit(3); add_digit(4); add_digit(0); run_entry(); finish_session("noise_fail", 1);
  endtask

  task automatic test_reset_mid_pass();
    add_digit(8); add_digit(4); add_digit(0);
    run_entry();
    done = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 5) done = 1'b0;
    end
    vectors++;
    if (led !== 2'b01) begin
      miscompares++;
      $display("FAIL mid_pass_led: got %b, expected 01", led);
    end
    #3 rst = 1'b0;
    #1;
    vectors++;
    if (led !== 2'b00) begin
      miscompares++;
      $display("FAIL async_reset_led: got %b, expected 00", led);
    end
    repeat (2) tick();
    rst = 1'b1;
    fails = 0;
    pq.delete();
    repeat (3) tick();
    add_digit(8); add_digit(4); add_digit(0); run_entry(); finish_session("after_reset", 0);
  endtask

  task automatic test_random();
    logic [9:0] one, v;
    int n, r, d;
    one = 10'd1;
    for (int s = 0; s < 20; s++) begin
      r = $urandom_range(3, 0);
      n = (r == 0) ? 2 : (r == 1) ? 4 : 3;
      for (int k = 0; k < n; k++) begin
        r = $urandom_range(9, 0);
        if (r == 0) begin
          v = 10'($urandom);
          while ($countones(v) < 2) v = 10'($urandom);
        end else begin
          d = $urandom_range(9, 0);
          if (r < 6 && k == 0) d = A1;
          if (r < 6 && k == 2) d = A2;
          v = one << d;
        end
        add_press(v, $urandom_range(8, 1), $urandom_range(5, 1));
      end
      run_entry();
      finish_session($sformatf("rand%0d", s), 1'($urandom_range(1, 0)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_in_result();
    test_reset_mid_pass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
